wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue_pkg.sv | 22 ++
 rtl/wb_queue_fifo.sv | 92 +++++++++
 rtl/wb_queue.sv | 156 +++++++++++++++
 tb/tb_wb_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// -----------------------------------------------------------------------------
// wb_queue_pkg
// Shared definitions for the write-back queue: register-number and data
// widths, the queued entry type {wn, d}, and a small hazard-compare helper.
// -----------------------------------------------------------------------------
package wb_queue_pkg;

    localparam int WN_W = 5;
    localparam int D_W  = 32;

    typedef struct packed {
        logic [WN_W-1:0] wn;
        logic [D_W-1:0]  d;
    } wb_entry_t;

    // r0 is hard-wired zero, so it never matches a pending write.
    function automatic logic wn_match(input logic [WN_W-1:0] entry_wn,
                                      input logic [WN_W-1:0] rn);
        return (rn != 5'd0) && (entry_wn == rn);
    endfunction

endpackage

// File: rtl/wb_queue_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// Storage and pointers for the write-back queue. Entries are kept in a
// circular buffer; the full contents are also presented in age order
// (index 0 = head / oldest) so the parent can run hazard compares.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset (pointers and count to 0)
//   push       enqueue push_entry this edge (ignored when full)
//   push_entry entry to enqueue
//   pop        dequeue the head this edge (ignored when empty)
//   head       current head entry (don't-care when empty)
//   full       count == DEPTH
//   empty      count == 0
//   count      occupied entries
//   ord_entry  entries in age order, oldest first
//   ord_valid  occupancy flag per age slot
// -----------------------------------------------------------------------------
module wbq_fifo
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                ord_entry [DEPTH],
    output logic [DEPTH-1:0]         ord_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    wb_entry_t       mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Entry storage; contents are not reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Age-ordered view: slot k is the k-th oldest entry.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ord
        assign ord_entry[k] = mem_r[rd_ptr_r + PW'(k)];
        assign ord_valid[k] = (CW'(k) < count_r);
    end

endmodule

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// Write-back queue between two result producers (ALU, load/mul-div) and a
// single register-file write port. ALU results have priority on enqueue;
// writes to r0 are accepted and dropped. The head entry drives the write
// port whenever the queue is non-empty and the port is not held. Pending
// writes are reported per read port so the issue stage can stall.
//
// Configuration
//   WBQ_BYPASS_EN  adds fwd_a/fwd_b: data of the youngest pending write to
//                  rna/rnb (0 when not busy).
//
// Ports
//   clk                         rising-edge clock
//   clr                         asynchronous active-high reset
//   a_valid/a_wn/a_d/a_ready    ALU result producer
//   m_valid/m_wn/m_d/m_ready    load / mul-div result producer
//   hold                        register-file write port unavailable
//   wn/d/we                     register-file write port
//   rna/rnb, busy_a/busy_b      pending-write query for two read ports
//   count                       occupied entries
//   fwd_a/fwd_b                 bypass data (WBQ_BYPASS_EN only)
// -----------------------------------------------------------------------------
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    a_valid,
    input  logic [4:0]              a_wn,
    input  logic [31:0]             a_d,
    output logic                    a_ready,
    input  logic                    m_valid,
    input  logic [4:0]              m_wn,
    input  logic [31:0]             m_d,
    output logic                    m_ready,
    input  logic                    hold,
    output logic [4:0]              wn,
    output logic [31:0]             d,
    output logic                    we,
    input  logic [4:0]              rna,
    input  logic [4:0]              rnb,
    output logic                    busy_a,
    output logic                    busy_b,
    output logic [$clog2(DEPTH):0]  count
`ifdef WBQ_BYPASS_EN
    ,
    output logic [31:0]             fwd_a,
    output logic [31:0]             fwd_b
`endif
);

    logic        full_s;
    logic        empty_s;
    logic        a_fire_s;
    logic        m_fire_s;
    logic        push_s;
    wb_entry_t   push_entry_s;
    wb_entry_t   head_s;
    wb_entry_t   ord_entry_s [DEPTH];
    logic [DEPTH-1:0] ord_valid_s;
    logic        busy_a_s;
    logic        busy_b_s;

    // Ready is dropped while full even if the head leaves this edge, so there
    // is never a same-cycle pass-through; clr forces both readies low.
    assign a_ready  = !full_s && !clr;
    assign m_ready  = !full_s && !a_valid && !clr;
    assign a_fire_s = a_valid && a_ready;
    assign m_fire_s = m_valid && m_ready;

    assign wn = head_s.wn;
    assign d  = head_s.d;
    assign we = !empty_s && !hold && !clr;

    assign busy_a = busy_a_s;
    assign busy_b = busy_b_s;

    // Enqueue selection: ALU wins, r0 results are consumed but not stored.
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '{wn: 5'd0, d: 32'd0};
        if (a_fire_s) begin
            push_s       = (a_wn != 5'd0);
            push_entry_s = '{wn: a_wn, d: a_d};
        end else if (m_fire_s) begin
            push_s       = (m_wn != 5'd0);
            push_entry_s = '{wn: m_wn, d: m_d};
        end else begin
            push_s       = 1'b0;
        end
    end

    wbq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .clr        (clr),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (we),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count),
        .ord_entry  (ord_entry_s),
        .ord_valid  (ord_valid_s)
    );

    // Hazard compare across every occupied entry, head included.
    always_comb begin
        busy_a_s = 1'b0;
        busy_b_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ord_valid_s[k] && wn_match(ord_entry_s[k].wn, rna)) begin
                busy_a_s = 1'b1;
            end else begin
                busy_a_s = busy_a_s;
            end
            if (ord_valid_s[k] && wn_match(ord_entry_s[k].wn, rnb)) begin
                busy_b_s = 1'b1;
            end else begin
                busy_b_s = busy_b_s;
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;

    assign fwd_a = fwd_a_s;
    assign fwd_b = fwd_b_s;

    // Bypass: walking oldest to youngest, the last match is the youngest.
    always_comb begin
        fwd_a_s = 32'd0;
        fwd_b_s = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ord_valid_s[k] && wn_match(ord_entry_s[k].wn, rna)) begin
                fwd_a_s = ord_entry_s[k].d;
            end else begin
                fwd_a_s = fwd_a_s;
            end
            if (ord_valid_s[k] && wn_match(ord_entry_s[k].wn, rnb)) begin
                fwd_b_s = ord_entry_s[k].d;
            end else begin
                fwd_b_s = fwd_b_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue
// Directed bench for wb_queue (DEPTH=4). Expected register-file writes are
// queued as stimulus is issued; a negedge monitor pops one for every cycle
// the DUT asserts we and compares {wn,d}. Direct checks cover ready, count
// and busy behaviour.
// -----------------------------------------------------------------------------
module tb_wb_queue;

    logic        clk;
    logic        clr;
    logic        a_valid;
    logic [4:0]  a_wn;
    logic [31:0] a_d;
    logic        a_ready;
    logic        m_valid;
    logic [4:0]  m_wn;
    logic [31:0] m_d;
    logic        m_ready;
    logic        hold;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        we;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        busy_a;
    logic        busy_b;
    logic [2:0]  count;
`ifdef WBQ_BYPASS_EN
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
`endif

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q [$];

    wb_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .a_valid (a_valid),
        .a_wn    (a_wn),
        .a_d     (a_d),
        .a_ready (a_ready),
        .m_valid (m_valid),
        .m_wn    (m_wn),
        .m_d     (m_d),
        .m_ready (m_ready),
        .hold    (hold),
        .wn      (wn),
        .d       (d),
        .we      (we),
        .rna     (rna),
        .rnb     (rnb),
        .busy_a  (busy_a),
        .busy_b  (busy_b),
        .count   (count)
`ifdef WBQ_BYPASS_EN
        ,
        .fwd_a   (fwd_a),
        .fwd_b   (fwd_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a cycle with we high at negedge is a write at the next rising edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wn=%0d d=0x%0h expected no write", wn, d);
            end else begin
                chk("write_order", {27'd0, wn, d}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int limit);
        for (int i = 0; i < limit && count != 3'd0; i++) begin
            step();
        end
        chk("drain", {61'd0, count}, 64'd0);
    endtask

    initial begin
        clr = 1'b1; a_valid = 1'b0; a_wn = 5'd0; a_d = 32'd0;
        m_valid = 1'b0; m_wn = 5'd0; m_d = 32'd0; hold = 1'b0;
        rna = 5'd0; rnb = 5'd0;

        // Reset state
        step();
        chk("rst_count",   {61'd0, count}, 64'd0);
        chk("rst_we",      {63'd0, we}, 64'd0);
        chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_m_ready", {63'd0, m_ready}, 64'd0);
        clr = 1'b0;

        // Single ALU write to r5
        step();
        a_valid = 1'b1; a_wn = 5'd5; a_d = 32'h1234; rna = 5'd5;
        exp_q.push_back({5'd5, 32'h1234});
        #1;
        chk("single_a_ready", {63'd0, a_ready}, 64'd1);
        step();
        a_valid = 1'b0;
        #1;
        chk("single_we",    {63'd0, we}, 64'd1);
        chk("single_wn",    {59'd0, wn}, 64'd5);
        chk("single_d",     {32'd0, d}, 64'h1234);
        chk("single_busy",  {63'd0, busy_a}, 64'd1);
        chk("single_count", {61'd0, count}, 64'd1);
        step();
        chk("single_count0", {61'd0, count}, 64'd0);
        chk("single_busy0",  {63'd0, busy_a}, 64'd0);

        // ALU priority over M producer
        a_valid = 1'b1; a_wn = 5'd3; a_d = 32'h33;
        m_valid = 1'b1; m_wn = 5'd4; m_d = 32'h44;
        exp_q.push_back({5'd3, 32'h33});
        exp_q.push_back({5'd4, 32'h44});
        #1;
        chk("prio_m_ready", {63'd0, m_ready}, 64'd0);
        chk("prio_a_ready", {63'd0, a_ready}, 64'd1);
        step();
        a_valid = 1'b0;
        #1;
        chk("prio_m_ready2", {63'd0, m_ready}, 64'd1);
        step();
        m_valid = 1'b0;
        wait_empty(10);

        // Fill under hold, then drain
        hold = 1'b1; rnb = 5'd3;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_wn = 5'(i + 1); a_d = 32'h100 + 32'(i);
            exp_q.push_back({5'(i + 1), 32'h100 + 32'(i)});
            step();
        end
        a_valid = 1'b0;
        #1;
        chk("full_count",   {61'd0, count}, 64'd4);
        chk("full_a_ready", {63'd0, a_ready}, 64'd0);
        chk("full_m_ready", {63'd0, m_ready}, 64'd0);
        chk("full_hold_we", {63'd0, we}, 64'd0);
        chk("full_busy_b",  {63'd0, busy_b}, 64'd1);
        hold = 1'b0;
        #1;
        chk("full_no_pass", {63'd0, a_ready}, 64'd0);
        for (int k = 3; k >= 0; k--) begin
            step();
            chk("drain_count", {61'd0, count}, 64'(k));
            if (k == 3) begin
                chk("ready_after_pop", {63'd0, a_ready}, 64'd1);
            end
        end

        // r0 write is accepted and dropped
        a_valid = 1'b1; a_wn = 5'd0; a_d = 32'hFFFF_FFFF; rna = 5'd0;
        #1;
        chk("r0_ready", {63'd0, a_ready}, 64'd1);
        step();
        a_valid = 1'b0;
        #1;
        chk("r0_count", {61'd0, count}, 64'd0);
        chk("r0_we",    {63'd0, we}, 64'd0);
        chk("r0_busy",  {63'd0, busy_a}, 64'd0);

        // Two writes to r7 under hold
        step();
        hold = 1'b1; rna = 5'd7; rnb = 5'd8;
        a_valid = 1'b1; a_wn = 5'd7; a_d = 32'd1;
        exp_q.push_back({5'd7, 32'd1});
        step();
        m_valid = 1'b1; a_valid = 1'b0; m_wn = 5'd7; m_d = 32'd2;
        exp_q.push_back({5'd7, 32'd2});
        step();
        m_valid = 1'b0;
        #1;
        chk("r7_count",  {61'd0, count}, 64'd2);
        chk("r7_busy",   {63'd0, busy_a}, 64'd1);
        chk("r8_busy_b", {63'd0, busy_b}, 64'd0);
`ifdef WBQ_BYPASS_EN
        chk("r7_fwd", {32'd0, fwd_a}, 64'd2);
        chk("r8_fwd", {32'd0, fwd_b}, 64'd0);
`endif
        hold = 1'b0;
        step();
        chk("r7_busy_mid", {63'd0, busy_a}, 64'd1);
`ifdef WBQ_BYPASS_EN
        chk("r7_fwd_mid", {32'd0, fwd_a}, 64'd2);
`endif
        step();
        chk("r7_busy_done", {63'd0, busy_a}, 64'd0);
        chk("r7_count0",    {61'd0, count}, 64'd0);

        // Reset with three entries pending: none of them may be written
        hold = 1'b1; rna = 5'd10; rnb = 5'd12;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_wn = 5'(10 + i); a_d = 32'hDEAD_0000 + 32'(i);
            step();
        end
        a_valid = 1'b0;
        #1;
        chk("pre_clr_count", {61'd0, count}, 64'd3);
        clr = 1'b1;
        #1;
        chk("clr_count",   {61'd0, count}, 64'd0);
        chk("clr_we",      {63'd0, we}, 64'd0);
        chk("clr_busy_a",  {63'd0, busy_a}, 64'd0);
        chk("clr_busy_b",  {63'd0, busy_b}, 64'd0);
        chk("clr_a_ready", {63'd0, a_ready}, 64'd0);
        step();
        clr = 1'b0; hold = 1'b0;
        repeat (5) step();
        chk("post_clr_count", {61'd0, count}, 64'd0);

        #20;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
